// File: rtl/mem_stage.sv
// Memory pipeline stage: waits for data-bus responses, aligns load data, forwards status.
// Optional MS_LOAD_FWD_EN macro lets aligned load data be bypassed in the response cycle.
module mem_stage #(
    parameter int ES_TO_MS_BUS_WD = 134,
    parameter int MS_TO_WS_BUS_WD = 125,
    parameter int DROP_CNT_W      = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    input  logic                       es_req_outstanding,
    input  logic                       data_sram_data_ok,
    input  logic [31:0]                data_sram_rdata,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic                       flush,
    output logic                       ms_ex,
    output logic                       ms_eret,
    output logic                       ms_mtc0,
    output logic                       ms_tlb_reflush,
    output logic [4:0]                 ms_dest,
    output logic [3:0]                 ms_gr_we,
    output logic [31:0]                ms_forward_data,
    output logic                       ms_forward_valid
);

    logic                       r_ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] r_es_bus;
    logic                       r_data_buf_valid;
    logic [31:0]                r_data_buf;
    logic [DROP_CNT_W-1:0]      r_drop_cnt;

    logic        w_tlbwi, w_tlbr, w_store, w_lw, w_bd, w_ex, w_eret, w_mtc0, w_mfc0;
    logic        w_lb, w_lbu, w_lh, w_lhu, w_lwl, w_lwr, w_res_from_mem;
    logic [31:0] w_badvaddr, w_result, w_pc;
    logic [7:0]  w_c0_addr;
    logic [4:0]  w_excode, w_dest;
    logic [3:0]  w_gr_we;

    assign {w_tlbwi, w_tlbr, w_store, w_lw, w_badvaddr, w_bd, w_c0_addr, w_ex, w_excode,
            w_eret, w_mtc0, w_mfc0, w_lb, w_lbu, w_lh, w_lhu, w_lwl, w_lwr, w_res_from_mem,
            w_gr_we, w_dest, w_result, w_pc} = r_es_bus;

    logic w_need_data, w_drop_zero, w_live_ok, w_ms_ready_go, w_leave, w_waiting;

    assign w_need_data    = r_ms_valid & (w_res_from_mem | w_store) & !w_ex;
    assign w_drop_zero    = (r_drop_cnt == '0);
    assign w_live_ok      = data_sram_data_ok & w_drop_zero;
    assign w_ms_ready_go  = !w_need_data | r_data_buf_valid | w_live_ok;
    assign ms_allowin     = !r_ms_valid | (w_ms_ready_go & ws_allowin);
    assign ms_to_ws_valid = r_ms_valid & w_ms_ready_go;
    assign w_leave        = ms_to_ws_valid & ws_allowin;
    assign w_waiting      = w_need_data & !r_data_buf_valid;

    // A response arriving with the flush belongs to the flushed instruction, so it is not counted.
    logic [DROP_CNT_W:0]   w_drop_sum;
    logic [DROP_CNT_W-1:0] w_drop_load;
    assign w_drop_sum  = {{DROP_CNT_W{1'b0}}, w_waiting & !data_sram_data_ok}
                       + {{DROP_CNT_W{1'b0}}, es_req_outstanding};
    assign w_drop_load = w_drop_sum[DROP_CNT_W] ? {DROP_CNT_W{1'b1}}
                                                : w_drop_sum[DROP_CNT_W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ms_valid       <= 1'b0;
            r_es_bus         <= '0;
            r_data_buf_valid <= 1'b0;
            r_data_buf       <= '0;
            r_drop_cnt       <= '0;
        end else begin
            if (flush) begin
                r_ms_valid <= 1'b0;
            end else if (ms_allowin) begin
                r_ms_valid <= es_to_ms_valid;
            end

            if (es_to_ms_valid && ms_allowin) begin
                r_es_bus <= es_to_ms_bus;
            end

            if (flush || w_leave) begin
                r_data_buf_valid <= 1'b0;
            end else if (w_waiting && w_live_ok) begin
                r_data_buf_valid <= 1'b1;
                r_data_buf       <= data_sram_rdata;
            end

            if (flush) begin
                r_drop_cnt <= w_drop_load;
            end else if (data_sram_data_ok && !w_drop_zero) begin
                r_drop_cnt <= r_drop_cnt - 1'b1;
            end
        end
    end

    logic [31:0] w_word, w_shr, w_shl, w_final_result;
    logic [15:0] w_half;
    logic [7:0]  w_byte;
    logic [1:0]  w_a;
    logic [3:0]  w_final_we;

    assign w_a    = w_result[1:0];
    assign w_word = r_data_buf_valid ? r_data_buf : data_sram_rdata;
    assign w_shr  = w_word >> {w_a, 3'b000};
    assign w_shl  = w_word << {~w_a, 3'b000};
    assign w_byte = w_shr[7:0];
    assign w_half = w_a[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        w_final_result = w_result;
        w_final_we     = w_gr_we;
        if (w_ex || w_store) begin
            w_final_we = 4'b0000;
        end else if (w_lw) begin
            w_final_result = w_word;
            w_final_we     = 4'b1111;
        end else if (w_lb || w_lbu) begin
            w_final_result = {{24{w_lb & w_byte[7]}}, w_byte};
        end else if (w_lh || w_lhu) begin
            w_final_result = {{16{w_lh & w_half[15]}}, w_half};
        end else if (w_lwl) begin
            w_final_result = w_shl;
            w_final_we     = 4'b1111 << ~w_a;
        end else if (w_lwr) begin
            w_final_result = w_shr;
            w_final_we     = 4'b1111 >> w_a;
        end
    end

    assign ms_to_ws_bus = {w_tlbwi, w_tlbr, w_badvaddr, w_bd, w_c0_addr, w_ex, w_excode,
                           w_eret, w_mtc0, w_mfc0, w_final_we, w_dest, w_final_result, w_pc};

    assign ms_ex           = r_ms_valid & w_ex;
    assign ms_eret         = r_ms_valid & w_eret;
    assign ms_mtc0         = r_ms_valid & w_mtc0;
    assign ms_tlb_reflush  = r_ms_valid & (w_tlbwi | w_tlbr);
    assign ms_dest         = r_ms_valid ? w_dest : 5'd0;
    assign ms_gr_we        = r_ms_valid ? w_final_we : 4'd0;
    assign ms_forward_data = w_final_result;

`ifdef MS_LOAD_FWD_EN
    assign ms_forward_valid = r_ms_valid & (!w_res_from_mem | r_data_buf_valid | w_live_ok);
`else
    // Without load bypass, decode stalls on any load sitting here.
    assign ms_forward_valid = r_ms_valid & !w_res_from_mem;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: table-driven load/align vectors with a handoff scoreboard,
// plus stall, discard-counter and asynchronous-reset sequences.
module tb_mem_stage;

    localparam int EW = 134;
    localparam int OW = 125;
    localparam int OpAlu = 0, OpLw = 1, OpLb = 2, OpLbu = 3, OpLh = 4, OpLhu = 5;
    localparam int OpLwl = 6, OpLwr = 7, OpSw = 8;
`ifdef MS_LOAD_FWD_EN
    localparam bit FwdEn = 1'b1;
`else
    localparam bit FwdEn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          ws_allowin;
    logic          ms_allowin;
    logic          es_to_ms_valid;
    logic [EW-1:0] es_to_ms_bus;
    logic          es_req_outstanding;
    logic          data_sram_data_ok;
    logic [31:0]   data_sram_rdata;
    logic          ms_to_ws_valid;
    logic [OW-1:0] ms_to_ws_bus;
    logic          flush;
    logic          ms_ex, ms_eret, ms_mtc0, ms_tlb_reflush;
    logic [4:0]    ms_dest;
    logic [3:0]    ms_gr_we;
    logic [31:0]   ms_forward_data;
    logic          ms_forward_valid;

    mem_stage dut (
        .clk                (clk),
        .reset              (reset),
        .ws_allowin         (ws_allowin),
        .ms_allowin         (ms_allowin),
        .es_to_ms_valid     (es_to_ms_valid),
        .es_to_ms_bus       (es_to_ms_bus),
        .es_req_outstanding (es_req_outstanding),
        .data_sram_data_ok  (data_sram_data_ok),
        .data_sram_rdata    (data_sram_rdata),
        .ms_to_ws_valid     (ms_to_ws_valid),
        .ms_to_ws_bus       (ms_to_ws_bus),
        .flush              (flush),
        .ms_ex              (ms_ex),
        .ms_eret            (ms_eret),
        .ms_mtc0            (ms_mtc0),
        .ms_tlb_reflush     (ms_tlb_reflush),
        .ms_dest            (ms_dest),
        .ms_gr_we           (ms_gr_we),
        .ms_forward_data    (ms_forward_data),
        .ms_forward_valid   (ms_forward_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  we;
        logic [31:0] pc;
        logic        fwd;
    } exp_t;

    typedef struct {
        int          op;
        logic [31:0] result;
        logic [31:0] rdata;
        logic        ex;
        logic [31:0] exp_res;
        logic [3:0]  exp_we;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[17];
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_handoff = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [EW-1:0] mk_bus(input int op, input logic [31:0] result,
                                             input logic ex, input logic [31:0] pc);
        logic [EW-1:0] b;
        b         = '0;
        b[131]    = (op == OpSw);
        b[130]    = (op == OpLw);
        b[129:98] = result;
        b[88]     = ex;
        b[87:83]  = ex ? 5'h04 : 5'h00;
        b[79]     = (op == OpLb);
        b[78]     = (op == OpLbu);
        b[77]     = (op == OpLh);
        b[76]     = (op == OpLhu);
        b[75]     = (op == OpLwl);
        b[74]     = (op == OpLwr);
        b[73]     = (op >= OpLw) && (op <= OpLwr);
        b[72:69]  = (op == OpSw) ? 4'h0 : 4'hF;
        b[68:64]  = 5'd7;
        b[63:32]  = result;
        b[31:0]   = pc;
        return b;
    endfunction

    // All driver tasks start and end 1 time unit after a rising edge.
    task automatic issue(input logic [EW-1:0] bus);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = bus;
        @(posedge clk);
        #1 es_to_ms_valid = 1'b0;
    endtask

    task automatic respond(input logic [31:0] rd);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = rd;
        @(posedge clk);
        #1 data_sram_data_ok = 1'b0;
        data_sram_rdata = 32'hDEAD_0000;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [31:0] res, input logic [3:0] we, input logic [31:0] pc,
                        input logic fwd);
        exp_t e;
        e.res = res;
        e.we  = we;
        e.pc  = pc;
        e.fwd = fwd;
        sb_q.push_back(e);
    endtask

    // Scoreboard monitor: compares every accepted handoff against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && ms_to_ws_valid && ws_allowin) begin
                n_handoff++;
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_handoff got pc=%h expected=none",
                             ms_to_ws_bus[31:0]);
                end else begin
                    e = sb_q.pop_front();
                    chk("final_result", ms_to_ws_bus[63:32], e.res);
                    chk("bus_gr_we", {28'd0, ms_to_ws_bus[72:69]}, {28'd0, e.we});
                    chk("pc", ms_to_ws_bus[31:0], e.pc);
                    chk("ms_gr_we", {28'd0, ms_gr_we}, {28'd0, e.we});
                    chk("fwd_valid", {31'd0, ms_forward_valid}, {31'd0, e.fwd});
                end
            end
        end
    end

    initial begin
        logic [31:0] pc;
        int          h0;
        bit          is_load;

        vecs[0]  = '{OpLw,  32'h1000, 32'h8899AABB, 1'b0, 32'h8899AABB, 4'hF};
        vecs[1]  = '{OpLb,  32'h1002, 32'h12F45678, 1'b0, 32'hFFFFFFF4, 4'hF};
        vecs[2]  = '{OpLbu, 32'h1002, 32'h12F45678, 1'b0, 32'h000000F4, 4'hF};
        vecs[3]  = '{OpLh,  32'h1002, 32'h12F45678, 1'b0, 32'h000012F4, 4'hF};
        vecs[4]  = '{OpLh,  32'h1000, 32'h12F45678, 1'b0, 32'h00005678, 4'hF};
        vecs[5]  = '{OpLhu, 32'h1000, 32'h12F48678, 1'b0, 32'h00008678, 4'hF};
        vecs[6]  = '{OpLh,  32'h1000, 32'h12F48678, 1'b0, 32'hFFFF8678, 4'hF};
        vecs[7]  = '{OpLb,  32'h1003, 32'h12F45678, 1'b0, 32'h00000012, 4'hF};
        vecs[8]  = '{OpLwl, 32'h1001, 32'hAABBCCDD, 1'b0, 32'hCCDD0000, 4'hC};
        vecs[9]  = '{OpLwr, 32'h1001, 32'hAABBCCDD, 1'b0, 32'h00AABBCC, 4'h7};
        vecs[10] = '{OpLwl, 32'h1000, 32'hAABBCCDD, 1'b0, 32'hDD000000, 4'h8};
        vecs[11] = '{OpLwl, 32'h1003, 32'hAABBCCDD, 1'b0, 32'hAABBCCDD, 4'hF};
        vecs[12] = '{OpLwr, 32'h1003, 32'hAABBCCDD, 1'b0, 32'h000000AA, 4'h1};
        vecs[13] = '{OpLwr, 32'h1000, 32'hAABBCCDD, 1'b0, 32'hAABBCCDD, 4'hF};
        vecs[14] = '{OpAlu, 32'h12345678, 32'h0, 1'b0, 32'h12345678, 4'hF};
        vecs[15] = '{OpSw,  32'h1008, 32'h0, 1'b0, 32'h00001008, 4'h0};
        vecs[16] = '{OpLw,  32'h1009, 32'h0, 1'b1, 32'h00001009, 4'h0};

        reset = 1'b1; ws_allowin = 1'b1; es_to_ms_valid = 1'b0; es_to_ms_bus = '0;
        es_req_outstanding = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = '0;
        flush = 1'b0;
        idle(2);
        chk("rst_out_valid", {31'd0, ms_to_ws_valid}, 32'd0);
        chk("rst_allowin", {31'd0, ms_allowin}, 32'd1);
        chk("rst_status", {28'd0, ms_ex, ms_eret, ms_mtc0, ms_tlb_reflush}, 32'd0);
        chk("rst_dest_we", {23'd0, ms_dest, ms_gr_we}, 32'd0);
        chk("rst_fwd", {31'd0, ms_forward_valid}, 32'd0);
        chk("rst_fwd_data", ms_forward_data, 32'd0);
        reset = 1'b0;
        idle(1);

        for (int i = 0; i < 17; i++) begin
            pc      = 32'hBFC0_0000 + 32'(4 * i);
            is_load = (vecs[i].op >= OpLw) && (vecs[i].op <= OpLwr);
            push(vecs[i].exp_res, vecs[i].exp_we, pc,
                 is_load ? (FwdEn && !vecs[i].ex) : 1'b1);
            issue(mk_bus(vecs[i].op, vecs[i].result, vecs[i].ex, pc));
            if (vecs[i].op != OpAlu && !vecs[i].ex) respond(vecs[i].rdata);
            else idle(1);
        end
        chk("table_sb_empty", sb_q.size(), 32'd0);

        // Response with writeback stalled: data must be buffered and handed off once.
        ws_allowin = 1'b0;
        push(32'hCAFEBABE, 4'hF, 32'h0000_2000, FwdEn);
        issue(mk_bus(OpLw, 32'h2000, 1'b0, 32'h0000_2000));
        respond(32'hCAFEBABE);
        repeat (2) begin
            @(negedge clk);
            chk("stall_allowin", {31'd0, ms_allowin}, 32'd0);
            chk("stall_valid", {31'd0, ms_to_ws_valid}, 32'd1);
            chk("stall_data", ms_to_ws_bus[63:32], 32'hCAFEBABE);
        end
        @(posedge clk);
        #1 ws_allowin = 1'b1;
        h0 = n_handoff;
        idle(1);
        @(negedge clk);
        chk("stall_one_handoff", n_handoff - h0, 32'd1);
        chk("stall_cleared", {31'd0, ms_to_ws_valid}, 32'd0);
        chk("stall_allowin_back", {31'd0, ms_allowin}, 32'd1);
        @(posedge clk);
        #1;

        // Flush of a waiting load with another request outstanding: two responses discarded.
        issue(mk_bus(OpLw, 32'h3000, 1'b0, 32'h0000_3000));
        es_req_outstanding = 1'b1;
        flush = 1'b1;
        idle(1);
        flush = 1'b0;
        es_req_outstanding = 1'b0;
        chk("drop_cnt_two", {30'd0, dut.r_drop_cnt}, 32'd2);
        chk("flush_clears", {31'd0, ms_allowin}, 32'd1);
        push(32'h5555AAAA, 4'hF, 32'h0000_3004, FwdEn);
        issue(mk_bus(OpLw, 32'h3004, 1'b0, 32'h0000_3004));
        for (int k = 0; k < 2; k++) begin
            data_sram_data_ok = 1'b1;
            data_sram_rdata   = 32'h11111111;
            @(negedge clk);
            chk("drop_ignored", {31'd0, ms_to_ws_valid}, 32'd0);
            @(posedge clk);
            #1 data_sram_data_ok = 1'b0;
        end
        chk("drop_cnt_zero", {30'd0, dut.r_drop_cnt}, 32'd0);
        respond(32'h5555AAAA);
        chk("drop_sb_empty", sb_q.size(), 32'd0);

        // Flush and response in the same cycle: that response belongs to the flushed load.
        issue(mk_bus(OpLw, 32'h4000, 1'b0, 32'h0000_4000));
        ws_allowin = 1'b0;
        es_req_outstanding = 1'b1;
        flush = 1'b1;
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h22222222;
        idle(1);
        flush = 1'b0; es_req_outstanding = 1'b0; data_sram_data_ok = 1'b0; ws_allowin = 1'b1;
        chk("drop_same_cycle", {30'd0, dut.r_drop_cnt}, 32'd1);
        chk("same_cycle_allowin", {31'd0, ms_allowin}, 32'd1);
        respond(32'h33333333);
        chk("drop_drained", {30'd0, dut.r_drop_cnt}, 32'd0);

        // Asynchronous reset in the middle of a waiting load with discards pending.
        issue(mk_bus(OpLw, 32'h5000, 1'b0, 32'h0000_5000));
        es_req_outstanding = 1'b1;
        flush = 1'b1;
        idle(1);
        flush = 1'b0;
        es_req_outstanding = 1'b0;
        issue(mk_bus(OpLw, 32'h5004, 1'b0, 32'h0000_5004));
        chk("pre_reset_allowin", {31'd0, ms_allowin}, 32'd0);
        #2 reset = 1'b1;
        #1;
        chk("async_allowin", {31'd0, ms_allowin}, 32'd1);
        chk("async_drop", {30'd0, dut.r_drop_cnt}, 32'd0);
        chk("async_dest_we", {23'd0, ms_dest, ms_gr_we}, 32'd0);
        chk("async_out_valid", {31'd0, ms_to_ws_valid}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        push(32'h0BADF00D, 4'hF, 32'h0000_6000, FwdEn);
        issue(mk_bus(OpLw, 32'h6000, 1'b0, 32'h0000_6000));
        respond(32'h0BADF00D);
        idle(1);
        chk("final_sb_empty", sb_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
